// File: rtl/kasumi_mem_pkg.sv
// Shared definitions for the load/store front-end: RV32I funct3 codes,
// response fault codes and the controller state encoding.
package kasumi_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the byte/halfword addressed by off from a full
// memory word and sign- or zero-extends it according to funct3.
module load_extend
    import kasumi_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, then extend it by access type.
    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'h0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'h0, lane_h};
            F3_W:    result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store front-end between the MEM stage and the banked data memory.
// One request in flight: decode/check, issue to memory, wait out the read
// latency, extract and extend the lane, and return a one-cycle response.
module lsu_mem_if
    import kasumi_mem_pkg::*;
#(
    parameter int          MEM_ADDR_W   = 13,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_fault,
    output logic                  mem_write,
    output logic [2:0]            mem_funct3,
    output logic [31:0]           mem_din,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [31:0]           mem_dout
);

    localparam int CNT_W = 3;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            off_lo_q, off_lo_d;
    logic [2:0]            f3_q, f3_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    fault_e                resp_fault_q, resp_fault_d;
    logic                  mem_write_q, mem_write_d;
    logic [2:0]            mem_funct3_q, mem_funct3_d;
    logic [31:0]           mem_din_q, mem_din_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [31:0] off;
    logic        misalign;
    logic        out_of_range;
    logic [31:0] ext_word;

    // Request decode: offset into memory, range and alignment checks.
    // Addresses below BASE_ADDR wrap to a huge offset and land in the range fault.
    always_comb begin
        off          = req_addr - BASE_ADDR;
        out_of_range = |off[31:MEM_ADDR_W];
        case (req_funct3)
            F3_B:    misalign = 1'b0;
            F3_H:    misalign = off[0];
            F3_W:    misalign = |off[1:0];
            // Unsigned variants have no store form, so a store using them is rejected.
            F3_BU:   misalign = req_write;
            F3_HU:   misalign = req_write | off[0];
            default: misalign = 1'b1;
        endcase
    end

    load_extend u_load_extend (
        .word   (mem_dout),
        .off    (off_lo_q),
        .funct3 (f3_q),
        .result (ext_word)
    );

    // Next-state and registered-output computation for the request FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_lo_d     = off_lo_q;
        f3_d         = f3_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        mem_write_d  = mem_write_q;
        mem_funct3_d = mem_funct3_q;
        mem_din_d    = mem_din_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_lo_d     = off[1:0];
                    f3_d         = req_funct3;
                    resp_rdata_d = 32'h0;
                    resp_fault_d = FAULT_NONE;
                    if (misalign) begin
                        resp_fault_d = FAULT_MISALIGN;
                        state_d      = RESP;
                    end else if (out_of_range) begin
                        resp_fault_d = FAULT_RANGE;
                        state_d      = RESP;
                    end else if (req_write) begin
                        mem_write_d  = 1'b1;
                        mem_funct3_d = req_funct3;
                        mem_din_d    = req_wdata;
                        mem_addr_d   = off[MEM_ADDR_W-1:0];
                        state_d      = ISSUE;
                    end else begin
                        mem_funct3_d = req_funct3;
                        mem_addr_d   = off[MEM_ADDR_W-1:0];
                        cnt_d        = CNT_W'(READ_LATENCY);
                        state_d      = WAIT;
                    end
                end
            end
            ISSUE: begin
                mem_write_d = 1'b0;
                state_d     = RESP;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    resp_rdata_d = ext_word;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_lo_q     <= '0;
            f3_q         <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= FAULT_NONE;
            mem_write_q  <= 1'b0;
            mem_funct3_q <= '0;
            mem_din_q    <= '0;
            mem_addr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_lo_q     <= off_lo_d;
            f3_q         <= f3_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_write_q  <= mem_write_d;
            mem_funct3_q <= mem_funct3_d;
            mem_din_q    <= mem_din_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_write  = mem_write_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_din    = mem_din_q;
    assign mem_addr   = mem_addr_q;

endmodule
